// File: rtl/packer_pkg.sv
// rtl/packer_pkg.sv - shared types and helpers for the lane packer
package packer_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Physical lane for the k-th packed item of a word.
  function automatic int lane_index(input int k, input bit msb_first, input int lanes);
    return msb_first ? (lanes - 1 - k) : k;
  endfunction

  function automatic int count_width(input int lanes);
    return $clog2(lanes + 1);
  endfunction

  function automatic int lane_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/lane_writer.sv
// rtl/lane_writer.sv - combinational single-lane write into the word accumulator
module lane_writer #(
  parameter int WIDTH    = 32,
  parameter int IN_WIDTH = 8,
  parameter int LW       = 2
) (
  input  logic [WIDTH-1:0]    i_acc,
  input  logic [IN_WIDTH-1:0] i_item,
  input  logic [LW-1:0]       i_lane,
  input  logic                i_we,
  output logic [WIDTH-1:0]    o_acc
);

  always_comb begin
    o_acc = i_acc;
    if (i_we) begin
      o_acc[int'(i_lane) * IN_WIDTH +: IN_WIDTH] = i_item;
    end
  end

endmodule

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - packs IN_WIDTH items into WIDTH words with early flush on last
module byte_packer import packer_pkg::*; #(
  parameter int WIDTH     = 32,
  parameter int IN_WIDTH  = 8,
  parameter int MSB_FIRST = 0,
  parameter int SKIP_ZERO = 0,
  localparam int LANES    = WIDTH / IN_WIDTH,
  localparam int CW       = count_width(LANES)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_WIDTH-1:0] in,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out,
  output logic [CW-1:0]       out_count
);

  localparam int LW = lane_width(LANES);

  state_t            r_state;
  state_t            w_state_next;
  logic [CW-1:0]     r_count;
  logic [WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]  r_out;
  logic [CW-1:0]     r_out_count;

  logic              w_out_valid;
  logic              w_accept;
  logic              w_skip;
  logic              w_write;
  logic [LW-1:0]     w_lane;
  logic [WIDTH-1:0]  w_acc_next;
  logic [CW-1:0]     w_count_next;
  logic              w_count_full;
  logic              w_close;
  logic              w_complete;

  assign in_ready = !w_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_skip   = (SKIP_ZERO != 0) && (in == '0);
  assign w_write  = w_accept && !w_skip;

  // r_count is always below LANES here: a full word closes on the same edge it fills.
  assign w_lane = LW'(lane_index(int'(r_count), MSB_FIRST != 0, LANES));

  lane_writer #(
    .WIDTH    (WIDTH),
    .IN_WIDTH (IN_WIDTH),
    .LW       (LW)
  ) u_lane_writer (
    .i_acc  (r_acc),
    .i_item (in),
    .i_lane (w_lane),
    .i_we   (w_write),
    .o_acc  (w_acc_next)
  );

  assign w_count_next = r_count + CW'(w_write);
  assign w_count_full = (w_count_next == CW'(LANES));
  assign w_close      = w_accept && (w_count_full || in_last);
  // A flush with nothing packed clears the accumulator but emits no word.
  assign w_complete   = w_close && (w_count_next != '0);

  always_comb begin
    w_state_next = r_state;
    w_out_valid  = 1'b0;
    unique case (r_state)
      FILL: begin
        if (w_complete) w_state_next = HOLD;
      end
      HOLD: begin
        w_out_valid = 1'b1;
        if (w_complete)     w_state_next = HOLD;
        else if (out_ready) w_state_next = FILL;
      end
      default: w_state_next = FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= FILL;
      r_count     <= '0;
      r_acc       <= '0;
      r_out       <= '0;
      r_out_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_close) begin
        r_acc   <= '0;
        r_count <= '0;
      end else if (w_accept) begin
        r_acc   <= w_acc_next;
        r_count <= w_count_next;
      end
      if (w_complete) begin
        r_out       <= w_acc_next;
        r_out_count <= w_count_next;
      end
    end
  end

  assign out_valid = w_out_valid;
  assign out       = r_out;
  assign out_count = r_out_count;

endmodule

// File: tb/tb_byte_packer.sv
// tb/tb_byte_packer.sv - directed vector bench for byte_packer
module tb_byte_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_ready;

  logic        rdy0, ov0, rdyM, ovM, rdyS, ovS;
  logic [31:0] out0, outM, outS;
  logic [2:0]  cnt0, cntM, cntS;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  byte_packer #(.WIDTH(32), .IN_WIDTH(8), .MSB_FIRST(0), .SKIP_ZERO(0)) dut0 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy0), .in(in_data),
    .in_last(in_last), .out_valid(ov0), .out_ready(out_ready), .out(out0), .out_count(cnt0));

  byte_packer #(.WIDTH(32), .IN_WIDTH(8), .MSB_FIRST(1), .SKIP_ZERO(0)) dut_msb (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdyM), .in(in_data),
    .in_last(in_last), .out_valid(ovM), .out_ready(out_ready), .out(outM), .out_count(cntM));

  byte_packer #(.WIDTH(32), .IN_WIDTH(8), .MSB_FIRST(0), .SKIP_ZERO(1)) dut_skip (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdyS), .in(in_data),
    .in_last(in_last), .out_valid(ovS), .out_ready(out_ready), .out(outS), .out_count(cntS));

  typedef struct {
    logic        iv;
    logic [7:0]  id;
    logic        il;
    logic        ordy;
    logic        e_rdy;
    logic        e_ov;
    logic [31:0] e_out;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic r);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    reset = 1'b1;
  endtask

  task automatic set_vec(input int i, input logic iv, input logic [7:0] id, input logic il,
                         input logic ordy, input logic e_rdy, input logic e_ov,
                         input logic [31:0] e_out, input logic [2:0] e_cnt);
    vecs[i].iv = iv;   vecs[i].id = id;     vecs[i].il = il;     vecs[i].ordy = ordy;
    vecs[i].e_rdy = e_rdy; vecs[i].e_ov = e_ov; vecs[i].e_out = e_out; vecs[i].e_cnt = e_cnt;
  endtask

  initial begin
    //         iv  data   last ordy  rdy  ov   out           cnt
    set_vec(0,  1, 8'h11, 0,   1,    1,   0,   32'h0,        3'd0);
    set_vec(1,  1, 8'h22, 0,   1,    1,   0,   32'h0,        3'd0);
    set_vec(2,  1, 8'h33, 0,   1,    1,   0,   32'h0,        3'd0);
    set_vec(3,  1, 8'h44, 0,   1,    1,   1,   32'h44332211, 3'd4);
    set_vec(4,  0, 8'h00, 0,   1,    1,   0,   32'h0,        3'd0);
    set_vec(5,  1, 8'hAA, 0,   1,    1,   0,   32'h0,        3'd0);
    set_vec(6,  1, 8'hBB, 1,   1,    1,   1,   32'h0000BBAA, 3'd2);
    set_vec(7,  1, 8'hCC, 0,   1,    1,   0,   32'h0,        3'd0);
    set_vec(8,  1, 8'hDD, 1,   0,    1,   1,   32'h0000DDCC, 3'd2);
    set_vec(9,  1, 8'hEE, 0,   0,    0,   1,   32'h0000DDCC, 3'd2);
    set_vec(10, 1, 8'hEE, 0,   0,    0,   1,   32'h0000DDCC, 3'd2);
    set_vec(11, 1, 8'hEE, 0,   1,    1,   0,   32'h0,        3'd0);
    set_vec(12, 1, 8'h01, 1,   1,    1,   1,   32'h000001EE, 3'd2);
    set_vec(13, 0, 8'h00, 0,   1,    1,   0,   32'h0,        3'd0);
    set_vec(14, 1, 8'h55, 1,   1,    1,   1,   32'h00000055, 3'd1);
    set_vec(15, 1, 8'h66, 1,   1,    1,   1,   32'h00000066, 3'd1);
    set_vec(16, 0, 8'h00, 0,   1,    1,   0,   32'h0,        3'd0);

    reset = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    chk("reset_out_valid", 32'(ov0), 32'd0);
    chk("reset_out", out0, 32'h0);
    chk("reset_out_count", 32'(cnt0), 32'd0);
    chk("reset_in_ready", 32'(rdy0), 32'd1);
    reset = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].iv, vecs[i].id, vecs[i].il, vecs[i].ordy);
      chk($sformatf("vec%0d_in_ready", i), 32'(rdy0), 32'(vecs[i].e_rdy));
      tick();
      chk($sformatf("vec%0d_out_valid", i), 32'(ov0), 32'(vecs[i].e_ov));
      if (vecs[i].e_ov) begin
        chk($sformatf("vec%0d_out", i), out0, vecs[i].e_out);
        chk($sformatf("vec%0d_out_count", i), 32'(cnt0), 32'(vecs[i].e_cnt));
      end
    end

    // Backpressure plus MSB-first fill on the same stream.
    do_reset();
    drive(1'b1, 8'h11, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h22, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h33, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h44, 1'b0, 1'b0); tick();
    chk("bp_word", out0, 32'h44332211);
    chk("msb_word", outM, 32'h11223344);
    chk("msb_count", 32'(cntM), 32'd4);
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 8'h77, 1'b0, 1'b0);
      chk($sformatf("bp_in_ready_c%0d", c), 32'(rdy0), 32'd0);
      tick();
      chk($sformatf("bp_out_valid_c%0d", c), 32'(ov0), 32'd1);
      chk($sformatf("bp_out_stable_c%0d", c), out0, 32'h44332211);
    end
    drive(1'b1, 8'h77, 1'b0, 1'b1);
    chk("bp_release_ready", 32'(rdy0), 32'd1);
    tick();
    chk("bp_release_valid", 32'(ov0), 32'd0);
    drive(1'b1, 8'h88, 1'b0, 1'b1); tick();
    drive(1'b1, 8'h99, 1'b0, 1'b1); tick();
    drive(1'b1, 8'hAA, 1'b0, 1'b1); tick();
    chk("bp_next_word", out0, 32'hAA998877);
    chk("bp_next_valid", 32'(ov0), 32'd1);

    // Zero suppression and empty flush.
    do_reset();
    drive(1'b1, 8'h01, 1'b0, 1'b1); tick();
    drive(1'b1, 8'h00, 1'b0, 1'b1); tick();
    drive(1'b1, 8'h02, 1'b0, 1'b1); tick();
    drive(1'b1, 8'h00, 1'b0, 1'b1); tick();
    drive(1'b1, 8'h03, 1'b0, 1'b1); tick();
    chk("skip_not_yet", 32'(ovS), 32'd0);
    drive(1'b1, 8'h04, 1'b0, 1'b1); tick();
    chk("skip_valid", 32'(ovS), 32'd1);
    chk("skip_word", outS, 32'h04030201);
    chk("skip_count", 32'(cntS), 32'd4);
    drive(1'b1, 8'h00, 1'b1, 1'b1); tick();
    chk("skip_empty_flush", 32'(ovS), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b1); tick();
    chk("skip_empty_flush_later", 32'(ovS), 32'd0);
    drive(1'b1, 8'h05, 1'b1, 1'b1); tick();
    chk("skip_after_flush", outS, 32'h00000005);
    chk("skip_after_flush_cnt", 32'(cntS), 32'd1);

    // Reset mid-word discards the partial lanes.
    do_reset();
    drive(1'b1, 8'h11, 1'b0, 1'b1); tick();
    drive(1'b1, 8'h22, 1'b0, 1'b1); tick();
    reset = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b1); tick();
    chk("midrst_out", out0, 32'h0);
    chk("midrst_valid", 32'(ov0), 32'd0);
    chk("midrst_count", 32'(cnt0), 32'd0);
    reset = 1'b1;
    drive(1'b1, 8'hA1, 1'b0, 1'b1); tick();
    drive(1'b1, 8'hA2, 1'b0, 1'b1); tick();
    drive(1'b1, 8'hA3, 1'b0, 1'b1); tick();
    drive(1'b1, 8'hA4, 1'b0, 1'b1); tick();
    chk("midrst_word", out0, 32'hA4A3A2A1);
    chk("midrst_word_cnt", 32'(cnt0), 32'd4);
    drive(1'b0, 8'h00, 1'b0, 1'b1); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
